// File: rtl/nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// nn_layer_sequencer
//
// Moves data between the host bus and the neural-network core for one complete
// inference run:
//   1. fetch the input image,
//   2. for each layer 0..last, fetch that layer's coefficients and then run the
//      core once on them.
// Bus words arrive on a valid/ready stream. They are packed little-endian into
// the image and coefficient byte vectors that feed the core. The block also
// supports a programmable layer count, bus backpressure and a synchronous abort.
// A sticky flag records any bus word that was offered while the sequencer was
// not accepting data.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   start             begin a run (only looked at in IDLE)
//   abort             synchronous return to IDLE from any busy state
//   cfg_last_layer    index of the final layer, captured together with start
//   get_image         request image words from the bus
//   get_coeffs        request coefficient words for `layer`
//   layer             index of the layer currently being loaded or computed
//   rd_data/rd_valid  bus word stream into the sequencer
//   rd_ready          sequencer accepts the word presented this cycle
//   image_data        packed image vector, byte 0 in [7:0]
//   coeff_data        packed coefficient vector, byte 0 in [7:0]
//   core_start        one-cycle pulse that launches the core on `layer`
//   core_done         core has finished the current layer
//   busy              high in every state except IDLE
//   done              one-cycle pulse when the run has completed
//   stray_err         sticky: rd_valid was seen while rd_ready was low
// -----------------------------------------------------------------------------
module nn_layer_sequencer #(
  parameter int IMBYTES = 6,
  parameter int CBYTES  = 11,
  parameter int LBITS   = 2,
  parameter int WORD_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LBITS-1:0]     cfg_last_layer,
  output logic                 get_image,
  output logic                 get_coeffs,
  output logic [LBITS-1:0]     layer,
  input  logic [WORD_W-1:0]    rd_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  output logic [IMBYTES*8-1:0] image_data,
  output logic [CBYTES*8-1:0]  coeff_data,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 done,
  output logic                 stray_err
);

  localparam int BPW     = WORD_W / 8;
  localparam int IMWORDS = (IMBYTES * 8 + WORD_W - 1) / WORD_W;
  localparam int CWORDS  = (CBYTES * 8 + WORD_W - 1) / WORD_W;
  localparam int MAXW    = (IMWORDS > CWORDS) ? IMWORDS : CWORDS;
  localparam int CNT_W   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_IMG,
    S_LOAD_COEF,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       wcnt_q, wcnt_d;
  logic [LBITS-1:0]       last_q, last_d;
  logic [LBITS-1:0]       layer_q, layer_d;
  logic [IMBYTES*8-1:0]   image_q, image_d;
  logic [CBYTES*8-1:0]    coeff_q, coeff_d;
  logic                   stray_q, stray_d;
  logic                   get_image_q, get_coeffs_q, rd_ready_q;
  logic                   core_start_q, busy_q, done_q;
  logic                   accept;

  // Word k covers bytes k*BPW upward. Bytes that would fall past the end of
  // the vector in the last word are dropped.
  function automatic logic [IMBYTES*8-1:0] pack_image(
    input logic [IMBYTES*8-1:0] vec,
    input logic [CNT_W-1:0]     k,
    input logic [WORD_W-1:0]    word
  );
    logic [IMBYTES*8-1:0] r;
    r = vec;
    for (int b = 0; b < BPW; b++) begin
      if (int'(k) * BPW + b < IMBYTES) begin
        r[(int'(k) * BPW + b) * 8 +: 8] = word[b * 8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [CBYTES*8-1:0] pack_coeff(
    input logic [CBYTES*8-1:0] vec,
    input logic [CNT_W-1:0]    k,
    input logic [WORD_W-1:0]   word
  );
    logic [CBYTES*8-1:0] r;
    r = vec;
    for (int b = 0; b < BPW; b++) begin
      if (int'(k) * BPW + b < CBYTES) begin
        r[(int'(k) * BPW + b) * 8 +: 8] = word[b * 8 +: 8];
      end
    end
    return r;
  endfunction

  // rd_ready is a registered copy of "in a load state", so it already gates
  // acceptance. The abort case is excluded separately in the FSM below.
  assign accept = rd_valid & rd_ready_q;

  always_comb begin
    // NOTE: every signal gets its default here, before any branch, so that no
    // path through the block leaves it unassigned and no latch is inferred.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    layer_d = layer_q;
    image_d = image_q;
    coeff_d = coeff_q;
    stray_d = stray_q;

    if (abort && state_q != S_IDLE) begin
      // abort beats the final-word and core_done transitions. The word
      // offered in this cycle is not taken.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD_IMG;
            last_d  = cfg_last_layer;
            layer_d = '0;
            stray_d = 1'b0;
            wcnt_d  = '0;
          end
        end
        S_LOAD_IMG: begin
          if (accept) begin
            image_d = pack_image(image_q, wcnt_q, rd_data);
            if (wcnt_q == CNT_W'(IMWORDS - 1)) begin
              state_d = S_LOAD_COEF;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + CNT_W'(1);
            end
          end
        end
        S_LOAD_COEF: begin
          if (accept) begin
            coeff_d = pack_coeff(coeff_q, wcnt_q, rd_data);
            if (wcnt_q == CNT_W'(CWORDS - 1)) begin
              state_d = S_COMPUTE;
              wcnt_d  = '0;
            end else begin
              wcnt_d = wcnt_q + CNT_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          // core_done is ignored while core_start is still high. A level left
          // over from the previous layer must not finish this one.
          if (core_done && !core_start_q) begin
            if (layer_q == last_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD_COEF;
              layer_d = layer_q + LBITS'(1);
              wcnt_d  = '0;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // A word offered while not ready is dropped and flagged. The flag is set
    // after the clear-on-start above, so a word dropped in the start cycle
    // still gets recorded.
    if (rd_valid && !rd_ready_q) begin
      stray_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the image/coefficient vectors are plain flops, not a RAM, and
      // they are reset along with the other state because every output has to
      // read 0 while in reset.
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      last_q       <= '0;
      layer_q      <= '0;
      image_q      <= '0;
      coeff_q      <= '0;
      stray_q      <= 1'b0;
      get_image_q  <= 1'b0;
      get_coeffs_q <= 1'b0;
      rd_ready_q   <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop here samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      last_q       <= last_d;
      layer_q      <= layer_d;
      image_q      <= image_d;
      coeff_q      <= coeff_d;
      stray_q      <= stray_d;
      // Outputs are registered from the next state, so they line up with the
      // state they describe without a combinational decode at the ports.
      get_image_q  <= (state_d == S_LOAD_IMG);
      get_coeffs_q <= (state_d == S_LOAD_COEF);
      rd_ready_q   <= (state_d == S_LOAD_IMG) || (state_d == S_LOAD_COEF);
      core_start_q <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
      busy_q       <= (state_d != S_IDLE);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign get_image  = get_image_q;
  assign get_coeffs = get_coeffs_q;
  assign layer      = layer_q;
  assign rd_ready   = rd_ready_q;
  assign image_data = image_q;
  assign coeff_data = coeff_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stray_err  = stray_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nn_layer_sequencer
//
// Self-checking bench for nn_layer_sequencer. The bench acts as both the bus
// and the core. Expected vectors are rebuilt from the bytes the bench actually
// handed over, using the little-endian packing rule. Expected pulse counts and
// layer order follow from the programmed layer count. All inputs are driven on
// the falling edge, and outputs are also sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_nn_layer_sequencer;

  localparam int IMBYTES = 6;
  localparam int CBYTES  = 11;
  localparam int LBITS   = 2;
  localparam int WORD_W  = 32;
  localparam int BPW     = WORD_W / 8;
  localparam int IMWORDS = (IMBYTES * 8 + WORD_W - 1) / WORD_W;
  localparam int CWORDS  = (CBYTES * 8 + WORD_W - 1) / WORD_W;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [LBITS-1:0]     cfg_last_layer = '0;
  logic                 get_image, get_coeffs;
  logic [LBITS-1:0]     layer;
  logic [WORD_W-1:0]    rd_data = '0;
  logic                 rd_valid = 1'b0;
  logic                 rd_ready;
  logic [IMBYTES*8-1:0] image_data;
  logic [CBYTES*8-1:0]  coeff_data;
  logic                 core_start;
  logic                 core_done = 1'b0;
  logic                 busy, done, stray_err;

  nn_layer_sequencer #(
    .IMBYTES(IMBYTES), .CBYTES(CBYTES), .LBITS(LBITS), .WORD_W(WORD_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_last_layer(cfg_last_layer), .get_image(get_image),
    .get_coeffs(get_coeffs), .layer(layer), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .image_data(image_data),
    .coeff_data(coeff_data), .core_start(core_start), .core_done(core_done),
    .busy(busy), .done(done), .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus words and the bench's own picture of the packed vectors.
  logic [WORD_W-1:0]    img_w  [IMWORDS];
  logic [WORD_W-1:0]    coef_w [4][CWORDS];
  logic [IMBYTES*8-1:0] model_img  = '0;
  logic [CBYTES*8-1:0]  model_coef = '0;

  // Pulse monitor.
  int               n_cstart = 0;
  int               n_done   = 0;
  logic [LBITS-1:0] layer_log[$];

  always @(negedge clk) begin
    if (core_start) begin
      n_cstart++;
      layer_log.push_back(layer);
    end
    if (done) n_done++;
  end

  function automatic logic [159:0] all_outs();
    return 160'({get_image, get_coeffs, layer, rd_ready, image_data,
                 coeff_data, core_start, busy, done, stray_err});
  endfunction

  // Offer n words (image, or coefficients of layer lyr).
  // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
  task automatic feed(input bit is_img, input int lyr, input int n,
                      input int mode);
    int k = 0;
    int cyc = 0;
    bit v;
    logic [WORD_W-1:0] w;
    while (k < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      w = is_img ? img_w[k] : coef_w[lyr][k];
      rd_valid = v;
      rd_data  = w;
      if (v && rd_ready) begin
        for (int b = 0; b < BPW; b++) begin
          if (k * BPW + b < (is_img ? IMBYTES : CBYTES)) begin
            if (is_img) model_img[(k * BPW + b) * 8 +: 8] = w[b * 8 +: 8];
            else        model_coef[(k * BPW + b) * 8 +: 8] = w[b * 8 +: 8];
          end
        end
        k++;
      end
    end
    check(is_img ? "img_words_taken" : "coef_words_taken", 160'(k), 160'(n));
  endtask

  task automatic randomize_words();
    for (int i = 0; i < IMWORDS; i++) img_w[i] = $urandom;
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < CWORDS; i++) coef_w[l][i] = $urandom;
  endtask

  // One full run. abort_layer < 0 means no abort.
  task automatic run(input int last, input int mode, input bit early,
                     input bit stray, input int abort_layer);
    int c0 = n_cstart;
    int d0 = n_done;
    bit exp_stray = 1'b0;
    layer_log.delete();
    @(negedge clk);
    start = 1'b1;
    cfg_last_layer = LBITS'(last);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 160'(busy), 160'(1));
    check("start_get_image", 160'(get_image), 160'(1));
    check("start_stray_clear", 160'(stray_err), 160'(0));
    check("start_layer", 160'(layer), 160'(0));
    feed(1'b1, 0, IMWORDS, mode);
    for (int l = 0; l <= last; l++) begin
      if (l == abort_layer) begin
        feed(1'b0, l, 1, 0);
        @(negedge clk);
        rd_valid = 1'b1;
        rd_data  = coef_w[l][1];
        abort    = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        abort    = 1'b0;
        check("abort_busy", 160'(busy), 160'(0));
        check("abort_rd_ready", 160'(rd_ready), 160'(0));
        check("abort_get_coeffs", 160'(get_coeffs), 160'(0));
        check("abort_coeff_data", 160'(coeff_data), 160'(model_coef));
        repeat (3) @(negedge clk);
        check("abort_no_done", 160'(n_done - d0), 160'(0));
        check("abort_idle", 160'(busy), 160'(0));
        return;
      end
      feed(1'b0, l, CWORDS, mode);
      @(negedge clk);
      rd_valid = 1'b0;
      check("core_start_pulse", 160'(core_start), 160'(1));
      check("compute_layer", 160'(layer), 160'(l));
      check("compute_coeff", 160'(coeff_data), 160'(model_coef));
      check("compute_image", 160'(image_data), 160'(model_img));
      check("compute_rd_ready", 160'(rd_ready), 160'(0));
      if (early) core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      check("core_start_one_cycle", 160'(core_start), 160'(0));
      check("still_compute", 160'({busy, get_coeffs, done}), 160'(3'b100));
      if (stray) begin
        rd_valid  = 1'b1;
        rd_data   = $urandom;
        exp_stray = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        check("stray_set", 160'(stray_err), 160'(1));
        check("stray_image_kept", 160'(image_data), 160'(model_img));
        check("stray_coeff_kept", 160'(coeff_data), 160'(model_coef));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("no_early_done", 160'(n_done - d0), 160'(0));
      @(negedge clk);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      if (l < last) begin
        check("next_get_coeffs", 160'(get_coeffs), 160'(1));
        check("next_layer", 160'(layer), 160'(l + 1));
      end else begin
        check("done_pulse", 160'({done, busy}), 160'(2'b11));
      end
    end
    @(negedge clk);
    check("after_done_idle", 160'({done, busy, get_image, get_coeffs}), 160'(0));
    check("core_start_count", 160'(n_cstart - c0), 160'(last + 1));
    check("done_count", 160'(n_done - d0), 160'(1));
    check("stray_sticky", 160'(stray_err), 160'(exp_stray));
    check("image_retained", 160'(image_data), 160'(model_img));
    check("coeff_retained", 160'(coeff_data), 160'(model_coef));
    check("layer_log_size", 160'(layer_log.size()), 160'(last + 1));
    foreach (layer_log[i]) check("layer_order", 160'(layer_log[i]), 160'(i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int d0;
    // 1: reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start          = 1'($urandom);
      abort          = 1'($urandom);
      rd_valid       = 1'($urandom);
      core_done      = 1'($urandom);
      rd_data        = $urandom;
      cfg_last_layer = LBITS'($urandom);
      #1;
      check("reset_outputs", all_outs(), 160'(0));
    end
    @(negedge clk);
    {start, abort, rd_valid, core_done} = '0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", all_outs(), 160'(0));
    end

    // 2: directed words, single layer.
    img_w[0] = 32'h44332211;
    img_w[1] = 32'hDEAD6655;
    coef_w[0][0] = 32'h04030201;
    coef_w[0][1] = 32'h08070605;
    coef_w[0][2] = 32'hFF0B0A09;
    run(0, 0, 1'b0, 1'b0, -1);
    check("t2_image", 160'(image_data), 160'(48'h665544332211));
    check("t2_coeff", 160'(coeff_data), 160'(88'h0B0A0908070605040302_01));

    // 3: three layers, valid every other cycle, core_done in core_start cycle.
    randomize_words();
    run(2, 1, 1'b1, 1'b0, -1);

    // 4: abort during 2nd coefficient word of layer 1, then a clean run.
    randomize_words();
    run(2, 0, 1'b0, 1'b0, 1);
    randomize_words();
    run(1, 2, 1'b0, 1'b0, -1);

    // 5: stray word in COMPUTE; the next start clears the flag.
    randomize_words();
    run(1, 2, 1'b0, 1'b1, -1);
    randomize_words();
    run(0, 0, 1'b0, 1'b0, -1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      randomize_words();
      run($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
          1'($urandom), -1);
    end

    // 6: reset mid COMPUTE with core_done high.
    randomize_words();
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    cfg_last_layer = LBITS'(0);
    @(negedge clk);
    start = 1'b0;
    feed(1'b1, 0, IMWORDS, 0);
    feed(1'b0, 0, CWORDS, 0);
    @(negedge clk);
    rd_valid = 1'b0;
    check("t6_core_start", 160'(core_start), 160'(1));
    @(negedge clk);
    core_done = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("t6_reset_immediate", all_outs(), 160'(0));
    @(negedge clk);
    check("t6_reset_held", all_outs(), 160'(0));
    check("t6_no_done", 160'(n_done - d0), 160'(0));
    reset = 1'b0;
    core_done = 1'b0;
    model_img = '0;
    model_coef = '0;
    repeat (2) @(negedge clk);
    check("t6_idle_after", all_outs(), 160'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
